// File: rtl/if_stage.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// if_stage : instruction fetch stage feeding the IF/ID pipeline register.
//
// Holds the architectural fetch PC and issues word-aligned fetches over a
// req/ack handshake with variable latency. Results land in the IF/ID
// register (instruction, pc, pc_plus_4, id_valid) consumed by decode.
// Decode stalls and redirects (jump / taken branch, no delay slots) are
// handled here.
//
// Ports
//   clk, rstn                      clock, async active-low reset
//   stall                          decode stall, IF/ID holds when 1
//   branch_taken, branch_target    taken-branch redirect from decode
//   jump, jump_target              jump redirect from decode (wins)
//   inst_req, inst_addr            fetch request / word address
//   inst_ack, inst_rdata           fetch response
//   instruction, pc, pc_plus_4     IF/ID register contents
//   id_valid                       IF/ID holds a real instruction
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_ack,
  input  logic [31:0] inst_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic [31:0] pc_plus_4,
  output logic        id_valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_r;
  logic [31:0] fetch_pc_r;
  logic [31:0] inst_addr_r;
  logic        inst_req_r;
  logic        discard_r;
  logic [31:0] buf_inst_r;
  logic [31:0] buf_pc_r;
  logic [31:0] instruction_r;
  logic [31:0] pc_r;
  logic [31:0] pc_plus_4_r;
  logic        id_valid_r;

  logic        redirect_s;
  logic [31:0] target_s;
  logic [31:0] pc_inc_s;

  // Redirect decode (jump has priority) and next sequential fetch address.
  always_comb begin
    redirect_s = jump | branch_taken;
    if (jump) begin
      target_s = jump_target & 32'hFFFF_FFFC;
    end else begin
      target_s = branch_target & 32'hFFFF_FFFC;
    end
    pc_inc_s = fetch_pc_r + 32'd4;
  end

  // Fetch FSM, fetch PC, skid buffer and IF/ID register.
  // inst_addr_r is only moved when no request is outstanding, so a request
  // in flight keeps its old address even after fetch_pc_r is redirected.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r       <= IDLE;
      fetch_pc_r    <= RESET_PC;
      inst_addr_r   <= RESET_PC;
      inst_req_r    <= 1'b0;
      discard_r     <= 1'b0;
      buf_inst_r    <= 32'd0;
      buf_pc_r      <= 32'd0;
      instruction_r <= NOP_INST;
      pc_r          <= 32'd0;
      pc_plus_4_r   <= 32'd0;
      id_valid_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          state_r     <= REQ;
          inst_req_r  <= 1'b1;
          inst_addr_r <= fetch_pc_r;
          if (!stall) begin
            instruction_r <= NOP_INST;
            id_valid_r    <= 1'b0;
          end
        end
        REQ: begin
          if (redirect_s) begin
            // Without an ack the old request is still in flight: drop its
            // response when it arrives. With an ack the response is dropped now.
            fetch_pc_r <= target_s;
            discard_r  <= ~inst_ack;
            if (inst_ack) begin
              inst_addr_r <= target_s;
            end
            if (!stall) begin
              instruction_r <= NOP_INST;
              id_valid_r    <= 1'b0;
            end
          end else if (inst_ack && discard_r) begin
            // Wrong-path response: ignore it and start the target fetch.
            discard_r   <= 1'b0;
            inst_addr_r <= fetch_pc_r;
            if (!stall) begin
              instruction_r <= NOP_INST;
              id_valid_r    <= 1'b0;
            end
          end else if (inst_ack && !stall) begin
            instruction_r <= inst_rdata;
            pc_r          <= fetch_pc_r;
            pc_plus_4_r   <= pc_inc_s;
            id_valid_r    <= 1'b1;
            fetch_pc_r    <= pc_inc_s;
            inst_addr_r   <= pc_inc_s;
          end else if (inst_ack) begin
            // Decode is stalled: park the word and stop requesting.
            buf_inst_r <= inst_rdata;
            buf_pc_r   <= fetch_pc_r;
            fetch_pc_r <= pc_inc_s;
            state_r    <= HOLD;
            inst_req_r <= 1'b0;
          end else if (!stall) begin
            instruction_r <= NOP_INST;
            id_valid_r    <= 1'b0;
          end
        end
        HOLD: begin
          if (redirect_s) begin
            fetch_pc_r  <= target_s;
            inst_addr_r <= target_s;
            state_r     <= REQ;
            inst_req_r  <= 1'b1;
            if (!stall) begin
              instruction_r <= NOP_INST;
              id_valid_r    <= 1'b0;
            end
          end else if (!stall) begin
            instruction_r <= buf_inst_r;
            pc_r          <= buf_pc_r;
            pc_plus_4_r   <= buf_pc_r + 32'd4;
            id_valid_r    <= 1'b1;
            inst_addr_r   <= fetch_pc_r;
            state_r       <= REQ;
            inst_req_r    <= 1'b1;
          end
        end
        default: begin
          state_r    <= IDLE;
          inst_req_r <= 1'b0;
        end
      endcase
    end
  end

  assign inst_req    = inst_req_r;
  assign inst_addr   = inst_addr_r;
  assign instruction = instruction_r;
  assign pc          = pc_r;
  assign pc_plus_4   = pc_plus_4_r;
  assign id_valid    = id_valid_r;

endmodule

// File: tb/tb_if_stage.sv
`timescale 1ns/1ps
// Testbench for if_stage: directed stimulus, memory responder with
// programmable latency, and a scoreboard queue checked by a separate monitor.
module tb_if_stage;

  logic        clk;
  logic        rstn;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ack;
  logic [31:0] inst_rdata;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] pc_plus_4;
  logic        id_valid;

  int n_checks = 0;
  int n_errors = 0;

  int mem_lat = 0;
  int mem_cnt = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;
  exp_t exp_q[$];

  if_stage dut (
    .clk          (clk),
    .rstn         (rstn),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_ack     (inst_ack),
    .inst_rdata   (inst_rdata),
    .instruction  (instruction),
    .pc           (pc),
    .pc_plus_4    (pc_plus_4),
    .id_valid     (id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Contents of instruction memory.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'hBFC0_0010) mem_word = 32'h2408_0005;
    else                    mem_word = a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_lat(input int n);
    mem_lat = n;
    mem_cnt = 0;
  endtask

  task automatic push(input logic [31:0] a);
    exp_t e;
    e.inst = mem_word(a);
    e.pc   = a;
    exp_q.push_back(e);
  endtask

  // Memory responder: acks after mem_lat idle cycles of an active request.
  initial begin
    inst_ack   = 1'b0;
    inst_rdata = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      #1;
      if (!rstn || !inst_req) begin
        inst_ack   = 1'b0;
        inst_rdata = 32'hDEAD_BEEF;
        mem_cnt    = 0;
      end else if (mem_cnt >= mem_lat) begin
        inst_ack   = 1'b1;
        inst_rdata = mem_word(inst_addr);
        mem_cnt    = 0;
      end else begin
        inst_ack   = 1'b0;
        inst_rdata = 32'hDEAD_BEEF;
        mem_cnt++;
      end
    end
  end

  // Monitor: every edge that loads a valid instruction (not stalled) pops one entry.
  initial begin
    logic s_stall;
    logic s_rst;
    exp_t e;
    forever begin
      @(posedge clk);
      s_stall = stall;
      s_rst   = rstn;
      #1;
      if (s_rst && rstn && !s_stall && id_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid_pc", pc, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("sb_instruction", instruction, e.inst);
          chk("sb_pc", pc, e.pc);
          chk("sb_pc_plus_4", pc_plus_4, e.pc + 32'd4);
        end
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_inst_req"}, {31'd0, inst_req}, 32'd0);
    chk({tag, "_id_valid"}, {31'd0, id_valid}, 32'd0);
    chk({tag, "_instruction"}, instruction, 32'h0000_0000);
    chk({tag, "_pc"}, pc, 32'd0);
    chk({tag, "_pc_plus_4"}, pc_plus_4, 32'd0);
  endtask

  // Directed stimulus; comments give negedge index after reset release.
  initial begin
    rstn = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
    jump = 1'b0; jump_target = 32'd0;
    set_lat(0);
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");

    // Back-to-back fetches from RESET_PC.
    push(32'hBFC0_0000);
    push(32'hBFC0_0004);
    rstn = 1'b1;                                         // N0
    @(negedge clk);                                      // N1
    chk("n1_inst_req", {31'd0, inst_req}, 32'd1);
    chk("n1_inst_addr", inst_addr, 32'hBFC0_0000);
    chk("n1_id_valid", {31'd0, id_valid}, 32'd0);
    @(negedge clk);                                      // N2
    chk("n2_inst_addr", inst_addr, 32'hBFC0_0004);
    @(negedge clk);                                      // N3
    chk("n3_inst_addr", inst_addr, 32'hBFC0_0008);
    push(32'hBFC0_0008);
    set_lat(3);

    // Three wait cycles: address held, bubbles in IF/ID.
    @(negedge clk);                                      // N4
    chk("wait_addr_4", inst_addr, 32'hBFC0_0008);
    chk("wait_valid", {31'd0, id_valid}, 32'd0);
    chk("wait_nop", instruction, 32'h0000_0000);
    chk("wait_pc_hold", pc, 32'hBFC0_0004);
    @(negedge clk);                                      // N5
    chk("wait_addr_5", inst_addr, 32'hBFC0_0008);
    @(negedge clk);                                      // N6
    chk("wait_addr_6", inst_addr, 32'hBFC0_0008);
    chk("wait_req_6", {31'd0, inst_req}, 32'd1);
    @(negedge clk);                                      // N7
    chk("n7_inst_addr", inst_addr, 32'hBFC0_000C);
    push(32'hBFC0_000C);
    set_lat(0);

    // Stall while the word at ...10 is acked.
    @(negedge clk);                                      // N8
    chk("n8_inst_addr", inst_addr, 32'hBFC0_0010);
    push(32'hBFC0_0010);
    stall = 1'b1;
    @(negedge clk);                                      // N9
    chk("hold_req_9", {31'd0, inst_req}, 32'd0);
    chk("hold_valid_9", {31'd0, id_valid}, 32'd1);
    chk("hold_inst_9", instruction, mem_word(32'hBFC0_000C));
    chk("hold_pc_9", pc, 32'hBFC0_000C);
    @(negedge clk);                                      // N10
    chk("hold_req_10", {31'd0, inst_req}, 32'd0);
    chk("hold_inst_10", instruction, mem_word(32'hBFC0_000C));
    stall = 1'b0;
    @(negedge clk);                                      // N11
    chk("resume_inst", instruction, 32'h2408_0005);
    chk("resume_valid", {31'd0, id_valid}, 32'd1);
    chk("resume_req", {31'd0, inst_req}, 32'd1);
    chk("resume_addr", inst_addr, 32'hBFC0_0014);
    set_lat(1000);

    // Taken branch while request to ...14 is outstanding.
    @(negedge clk);                                      // N12
    branch_taken = 1'b1; branch_target = 32'h0000_1003;
    @(negedge clk);                                      // N13
    branch_taken = 1'b0;
    chk("br_req_held", {31'd0, inst_req}, 32'd1);
    chk("br_addr_held", inst_addr, 32'hBFC0_0014);
    push(32'h0000_1000);
    set_lat(0);
    @(negedge clk);                                      // N14
    chk("br_target_addr", inst_addr, 32'h0000_1000);
    chk("br_bubble", {31'd0, id_valid}, 32'd0);
    @(negedge clk);                                      // N15
    chk("br_next_addr", inst_addr, 32'h0000_1004);
    set_lat(1000);

    // Jump and branch together, with an ack in the same cycle.
    @(negedge clk);                                      // N16
    jump = 1'b1; jump_target = 32'h0000_2000;
    branch_taken = 1'b1; branch_target = 32'h0000_3000;
    set_lat(0);
    @(negedge clk);                                      // N17
    jump = 1'b0; branch_taken = 1'b0;
    chk("jmp_prio_addr", inst_addr, 32'h0000_2000);
    chk("jmp_bubble", {31'd0, id_valid}, 32'd0);
    push(32'h0000_2000);
    @(negedge clk);                                      // N18
    chk("jmp_next_addr", inst_addr, 32'h0000_2004);
    set_lat(1000);

    // Jump to the top of the address space: pc wraps to 0.
    @(negedge clk);                                      // N19
    jump = 1'b1; jump_target = 32'hFFFF_FFFF;
    @(negedge clk);                                      // N20
    jump = 1'b0;
    chk("wrap_old_addr", inst_addr, 32'h0000_2004);
    set_lat(0);
    @(negedge clk);                                      // N21
    chk("wrap_addr", inst_addr, 32'hFFFF_FFFC);
    chk("wrap_bubble", {31'd0, id_valid}, 32'd0);
    push(32'hFFFF_FFFC);
    @(negedge clk);                                      // N22
    chk("wrap_next_addr", inst_addr, 32'h0000_0000);
    chk("wrap_pc_plus_4", pc_plus_4, 32'h0000_0000);
    set_lat(1000);

    // Reset pulsed in the middle of a fetch.
    @(negedge clk);                                      // N23
    #2 rstn = 1'b0;
    #1 chk_reset_outputs("midreset");
    @(negedge clk);                                      // N24
    rstn = 1'b1;
    set_lat(0);
    push(32'hBFC0_0000);
    @(negedge clk);                                      // N25
    chk("rst2_req", {31'd0, inst_req}, 32'd1);
    chk("rst2_addr", inst_addr, 32'hBFC0_0000);
    @(negedge clk);                                      // N26
    set_lat(1000);
    chk("rst2_valid", {31'd0, id_valid}, 32'd1);
    repeat (3) @(negedge clk);
    chk("sb_queue_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
